// File: rtl/light_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : light_sequencer_if
// Description : Bundle between the intersection light sequencer and its
//               surroundings.
//               - Interval counter handshake: time_value, contando, terminado.
//               - Operator inputs: ped_req, night_mode.
//               - Lamp, status and debug outputs.
//               The master modport is the sequencer. The slave modport is the
//               counter/lamp environment.
// Ports (signals):
//   terminado  : one-cycle interval-done pulse from the counter
//   ped_req    : pedestrian button, level
//   night_mode : request flash operation
//   time_value : interval length handed to the counter
//   contando   : counter run enable
//   ns_light   : north-south lamps {red,yellow,green}
//   ew_light   : east-west lamps {red,yellow,green}
//   walk       : pedestrian walk lamp
//   fault      : sticky watchdog fault
//   state_o    : current state encoding (debug)
// Revision    : 1.0 - initial release
// ============================================================================
interface light_sequencer_if;
  logic       terminado;
  logic       ped_req;
  logic       night_mode;
  logic [3:0] time_value;
  logic       contando;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       fault;
  logic [3:0] state_o;

  modport master (
    input  terminado, ped_req, night_mode,
    output time_value, contando, ns_light, ew_light, walk, fault, state_o
  );

  modport slave (
    output terminado, ped_req, night_mode,
    input  time_value, contando, ns_light, ew_light, walk, fault, state_o
  );
endinterface
`default_nettype wire

// File: rtl/light_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : light_sequencer
// Description : Intersection light controller.
//               - Acts as initiator of the interval-timer handshake.
//               - Each state runs a LOAD phase (counter idle for one cycle),
//                 then a RUN phase until the counter reports terminado.
//               - Sequences two roads, a latched pedestrian walk phase and a
//                 night flash mode.
//               - A watchdog locks the controller into FAULT when terminado
//                 never arrives.
// Ports:
//   div_clk : clock
//   rst     : asynchronous, active-high reset
//   bus     : light_sequencer_if.master
//             - inputs : terminado, ped_req, night_mode
//             - outputs: time_value, contando, ns_light, ew_light, walk,
//                        fault, state_o
// Revision    : 1.0 - initial release
// ============================================================================
module light_sequencer #(
  parameter logic [3:0] T_GREEN  = 4'd9,
  parameter logic [3:0] T_YELLOW = 4'd2,
  parameter logic [3:0] T_ALLRED = 4'd1,
  parameter logic [3:0] T_WALK   = 4'd7,
  parameter logic [3:0] T_FLASH  = 4'd3,
  parameter logic [4:0] WDOG     = 5'd20
) (
  input  logic                div_clk,
  input  logic                rst,
  light_sequencer_if.master   bus
);

  typedef enum logic [3:0] {
    NS_GREEN  = 4'd0,
    NS_YELLOW = 4'd1,
    ALL_RED1  = 4'd2,
    EW_GREEN  = 4'd3,
    EW_YELLOW = 4'd4,
    ALL_RED2  = 4'd5,
    WALK      = 4'd6,
    FLASH     = 4'd7,
    FAULT     = 4'd8
  } state_t;

  typedef enum logic {
    PH_LOAD = 1'b0,
    PH_RUN  = 1'b1
  } phase_t;

  localparam logic [2:0] c_RED    = 3'b100;
  localparam logic [2:0] c_YELLOW = 3'b010;
  localparam logic [2:0] c_GREEN  = 3'b001;
  localparam logic [2:0] c_DARK   = 3'b000;

  // The check happens on the edge that would make the count WDOG. FAULT is
  // therefore entered exactly WDOG cycles after contando rose.
  localparam logic [4:0] c_WDOG_LAST = WDOG - 5'd1;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t     state_q;
  phase_t     phase_q;
  logic       contando_q;
  logic [3:0] time_value_q;
  logic [2:0] ns_light_q;
  logic [2:0] ew_light_q;
  logic       walk_q;
  logic       fault_q;
  logic       ped_pend_q;
  logic [4:0] wdog_q;
  logic       flash_ph_q;

  // Next-state candidates, used only on a terminado edge in RUN.
  state_t     state_d;
  logic       flash_ph_d;
  logic [6:0] lamps_d;      // {ns_light, ew_light, walk}

  // --------------------------------------------------------------------------
  // Helper functions
  // --------------------------------------------------------------------------
  function automatic state_t next_state(input state_t s,
                                        input logic   night,
                                        input logic   ped);
    state_t n;
    case (s)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALL_RED1;
      ALL_RED1:  n = night ? FLASH : EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALL_RED2;
      // Night mode has priority over a pending pedestrian request.
      ALL_RED2:  n = night ? FLASH : (ped ? WALK : NS_GREEN);
      WALK:      n = NS_GREEN;
      FLASH:     n = night ? FLASH : ALL_RED2;
      default:   n = FAULT;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] time_for(input state_t s);
    logic [3:0] t;
    case (s)
      NS_GREEN, EW_GREEN:   t = T_GREEN;
      NS_YELLOW, EW_YELLOW: t = T_YELLOW;
      WALK:                 t = T_WALK;
      FLASH:                t = T_FLASH;
      default:              t = T_ALLRED;
    endcase
    return t;
  endfunction

  function automatic logic [6:0] lamps_for(input state_t s, input logic fph);
    logic [6:0] l;
    case (s)
      NS_GREEN:  l = {c_GREEN,  c_RED,    1'b0};
      NS_YELLOW: l = {c_YELLOW, c_RED,    1'b0};
      EW_GREEN:  l = {c_RED,    c_GREEN,  1'b0};
      EW_YELLOW: l = {c_RED,    c_YELLOW, 1'b0};
      WALK:      l = {c_RED,    c_RED,    1'b1};
      FLASH:     l = {fph ? c_YELLOW : c_DARK, fph ? c_YELLOW : c_DARK, 1'b0};
      default:   l = {c_RED,    c_RED,    1'b0};
    endcase
    return l;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = next_state(state_q, bus.night_mode, ped_pend_q);
    // The flash phase toggles only while staying in FLASH. Each fresh entry
    // starts on the dark half, so the pattern is deterministic.
    flash_ph_d = ((state_q == FLASH) && (state_d == FLASH)) ? ~flash_ph_q : 1'b0;
    lamps_d    = lamps_for(state_d, flash_ph_d);
  end

  // --------------------------------------------------------------------------
  // State machine with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ALL_RED2;
      phase_q      <= PH_LOAD;
      contando_q   <= 1'b0;
      time_value_q <= T_ALLRED;
      ns_light_q   <= c_RED;
      ew_light_q   <= c_RED;
      walk_q       <= 1'b0;
      fault_q      <= 1'b0;
      ped_pend_q   <= 1'b0;
      wdog_q       <= 5'd0;
      flash_ph_q   <= 1'b0;
    end else if (state_q != FAULT) begin
      // Requests are not latched while flashing; FAULT never gets here.
      if (bus.ped_req && (state_q != FLASH)) begin
        ped_pend_q <= 1'b1;
      end

      if (phase_q == PH_LOAD) begin
        // One idle cycle lets the counter reload; terminado is ignored here.
        phase_q    <= PH_RUN;
        contando_q <= 1'b1;
        wdog_q     <= 5'd0;
      end else if (bus.terminado) begin
        state_q      <= state_d;
        phase_q      <= PH_LOAD;
        contando_q   <= 1'b0;
        time_value_q <= time_for(state_d);
        ns_light_q   <= lamps_d[6:4];
        ew_light_q   <= lamps_d[3:1];
        walk_q       <= lamps_d[0];
        flash_ph_q   <= flash_ph_d;
        // Written after the latch above, so a press on the entry edge is
        // consumed by this walk phase rather than queued for the next round.
        if (state_d == WALK) begin
          ped_pend_q <= 1'b0;
        end
      end else if (wdog_q == c_WDOG_LAST) begin
        state_q    <= FAULT;
        phase_q    <= PH_LOAD;
        contando_q <= 1'b0;
        ns_light_q <= c_RED;
        ew_light_q <= c_RED;
        walk_q     <= 1'b0;
        fault_q    <= 1'b1;
      end else begin
        wdog_q <= wdog_q + 5'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.time_value = time_value_q;
  assign bus.contando   = contando_q;
  assign bus.ns_light   = ns_light_q;
  assign bus.ew_light   = ew_light_q;
  assign bus.walk       = walk_q;
  assign bus.fault      = fault_q;
  assign bus.state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_light_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_light_sequencer
// Description : Self-checking bench for light_sequencer.
//               - A behavioural interval counter is attached to the handshake.
//               - A dwell-count reference model predicts every output each
//                 cycle.
//               - Directed sequences cover the pedestrian, flash, watchdog and
//                 reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_light_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  light_sequencer_if bus ();

  light_sequencer dut (
    .div_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  // --------------------------------------------------------------------------
  // Interval counter: idle while contando=0. Pulses terminado so that each
  // state dwells time_value+3 cycles. The stub can override it.
  // --------------------------------------------------------------------------
  logic [4:0] cnt_q       = 5'd0;
  logic       term_q      = 1'b0;
  logic       stub_hold   = 1'b0;
  logic       manual_term = 1'b0;

  always @(posedge clk) begin
    if (!bus.contando) begin
      cnt_q  <= 5'd0;
      term_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + 5'd1;
      term_q <= (cnt_q == {1'b0, bus.time_value});
    end
  end

  assign bus.terminado = stub_hold ? manual_term : term_q;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model.
  // Tracks the state and the cycles left in its dwell. contando is low only
  // on the first cycle of each dwell.
  // --------------------------------------------------------------------------
  int m_state;
  int m_left;
  bit m_ped;
  bit m_fph;
  bit model_on = 1'b0;

  function automatic int tv_of(input int s);
    case (s)
      0, 3:    return 9;
      1, 4:    return 2;
      6:       return 7;
      7:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int dwell_of(input int s);
    return tv_of(s) + 3;
  endfunction

  function automatic logic [6:0] lamps_of(input int s, input bit fph);
    case (s)
      0:       return {3'b001, 3'b100, 1'b0};
      1:       return {3'b010, 3'b100, 1'b0};
      3:       return {3'b100, 3'b001, 1'b0};
      4:       return {3'b100, 3'b010, 1'b0};
      6:       return {3'b100, 3'b100, 1'b1};
      7:       return fph ? {3'b010, 3'b010, 1'b0} : 7'b0;
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    m_state = 5;
    m_left  = dwell_of(5);
    m_ped   = 1'b0;
    m_fph   = 1'b0;
  endtask

  task automatic model_edge(input bit ped, input bit night);
    int nxt;
    bit old_ped;
    old_ped = m_ped;
    if (ped && m_state != 7) m_ped = 1'b1;
    m_left--;
    if (m_left == 0) begin
      case (m_state)
        0:       nxt = 1;
        1:       nxt = 2;
        2:       nxt = night ? 7 : 3;
        3:       nxt = 4;
        4:       nxt = 5;
        5:       nxt = night ? 7 : (old_ped ? 6 : 0);
        6:       nxt = 0;
        default: nxt = night ? 7 : 5;
      endcase
      m_fph = (m_state == 7 && nxt == 7) ? !m_fph : 1'b0;
      if (nxt == 6) m_ped = 1'b0;
      m_state = nxt;
      m_left  = dwell_of(nxt);
    end
  endtask

  task automatic model_compare();
    logic [16:0] e;
    logic [16:0] a;
    logic [6:0]  l;
    logic [3:0]  st;
    logic [3:0]  tv;
    l  = lamps_of(m_state, m_fph);
    st = 4'(m_state);
    tv = 4'(tv_of(m_state));
    e  = {st, l, (m_left != dwell_of(m_state)), tv, 1'b0};
    a  = {bus.state_o, bus.ns_light, bus.ew_light, bus.walk, bus.contando,
          bus.time_value, bus.fault};
    check("model", {15'd0, a}, {15'd0, e});
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    bit p;
    bit n;
    p = bus.ped_req;
    n = bus.night_mode;
    @(posedge clk);
    if (model_on) model_edge(p, n);
    #1;
    if (model_on) model_compare();
  endtask

  task automatic wait_state(input int s, input string tag);
    int n;
    n = 0;
    while (int'(bus.state_o) != s && n < 80) begin
      step();
      n++;
    end
    check({"reach_", tag}, {28'd0, bus.state_o}, s);
  endtask

  task automatic wait_leave(output int n);
    logic [3:0] s0;
    s0 = bus.state_o;
    n  = 0;
    do begin
      step();
      n++;
    end while (bus.state_o == s0 && n < 80);
  endtask

  task automatic wait_lamp(output int n);
    logic [2:0] l0;
    l0 = bus.ns_light;
    n  = 0;
    do begin
      step();
      n++;
    end while (bus.ns_light == l0 && n < 80);
  endtask

  typedef struct {
    int         st;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    int         dwell;
  } row_t;

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    row_t tbl[7];
    int   n;

    tbl[0] = '{5, 3'b100, 3'b100, 1'b0, 4};
    tbl[1] = '{0, 3'b001, 3'b100, 1'b0, 12};
    tbl[2] = '{1, 3'b010, 3'b100, 1'b0, 5};
    tbl[3] = '{2, 3'b100, 3'b100, 1'b0, 4};
    tbl[4] = '{3, 3'b100, 3'b001, 1'b0, 12};
    tbl[5] = '{4, 3'b100, 3'b010, 1'b0, 5};
    tbl[6] = '{5, 3'b100, 3'b100, 1'b0, 4};

    bus.ped_req    = 1'b0;
    bus.night_mode = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",    {28'd0, bus.state_o}, 5);
    check("rst_lamps",    {25'd0, bus.ns_light, bus.ew_light, bus.walk}, 32'b1001000);
    check("rst_contando", {31'd0, bus.contando}, 0);
    check("rst_tv",       {28'd0, bus.time_value}, 1);
    check("rst_fault",    {31'd0, bus.fault}, 0);
    rst = 1'b0;
    model_reset();
    model_on = 1'b1;

    // 1: full round, table-driven lamp values and dwell lengths
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t1_state%0d", i), {28'd0, bus.state_o}, tbl[i].st);
      check($sformatf("t1_lamps%0d", i), {25'd0, bus.ns_light, bus.ew_light, bus.walk},
            {25'd0, tbl[i].ns, tbl[i].ew, tbl[i].walk});
      wait_leave(n);
      check($sformatf("t1_dwell%0d", i), n, tbl[i].dwell);
    end

    // 2: one-cycle press during NS_GREEN is served by a walk phase
    bus.ped_req = 1'b1; step(); bus.ped_req = 1'b0;
    wait_state(6, "t2_walk");
    check("t2_walk_lamps", {25'd0, bus.ns_light, bus.ew_light, bus.walk}, 32'b1001001);
    wait_leave(n);
    check("t2_walk_dwell", n, 10);
    check("t2_after_walk", {28'd0, bus.state_o}, 0);
    wait_state(5, "t2_ar2");
    wait_leave(n);
    check("t2_no_rewalk", {28'd0, bus.state_o}, 0);

    // 3: press on the walk-entry edge is consumed; press during walk repeats
    bus.ped_req = 1'b1; step(); bus.ped_req = 1'b0;
    wait_state(5, "t3_ar2");
    repeat (3) step();
    bus.ped_req = 1'b1; step(); bus.ped_req = 1'b0;
    check("t3_entered_walk", {28'd0, bus.state_o}, 6);
    wait_state(5, "t3_ar2b");
    wait_leave(n);
    check("t3_no_second_walk", {28'd0, bus.state_o}, 0);
    bus.ped_req = 1'b1; step(); bus.ped_req = 1'b0;
    wait_state(6, "t3_walk2");
    repeat (2) step();
    bus.ped_req = 1'b1; step(); bus.ped_req = 1'b0;
    wait_state(0, "t3_nsg");
    wait_state(5, "t3_ar2c");
    wait_leave(n);
    check("t3_walk_repeat", {28'd0, bus.state_o}, 6);

    // 4: night mode raised mid-green takes effect at the end of ALL_RED1
    wait_state(0, "t4_nsg");
    repeat (3) step();
    bus.night_mode = 1'b1;
    wait_state(2, "t4_ar1");
    wait_leave(n);
    check("t4_flash_entry", {28'd0, bus.state_o}, 7);
    check("t4_flash_dark", {26'd0, bus.ns_light, bus.ew_light}, 0);
    wait_lamp(n);
    check("t4_half1", n, 6);
    check("t4_yellow_on", {26'd0, bus.ns_light, bus.ew_light}, 32'b010010);
    wait_lamp(n);
    check("t4_half2", n, 6);
    bus.night_mode = 1'b0;
    wait_state(5, "t4_ar2");
    wait_leave(n);
    check("t4_resume", {28'd0, bus.state_o}, 0);

    // 6: asynchronous reset mid EW_GREEN
    wait_state(3, "t6_ewg");
    repeat (4) step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_state", {28'd0, bus.state_o}, 5);
    check("t6_async_out", {20'd0, bus.ns_light, bus.ew_light, bus.walk, bus.contando,
                           bus.time_value, bus.fault}, {20'd0, 3'b100, 3'b100, 1'b0, 1'b0, 4'd1, 1'b0});
    @(posedge clk);
    #1 rst = 1'b0;
    wait_leave(n);
    check("t6_restart_dwell", n, 4);
    check("t6_restart_next", {28'd0, bus.state_o}, 0);

    // Random ped/night stimulus against the reference model
    for (int k = 0; k < 1500; k++) begin
      bus.ped_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 149) == 0) bus.night_mode = !bus.night_mode;
      step();
    end
    bus.ped_req    = 1'b0;
    bus.night_mode = 1'b0;

    // 5: counter never finishes -> watchdog fault
    model_on    = 1'b0;
    rst         = 1'b1;
    stub_hold   = 1'b1;
    manual_term = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5_contando_low", {31'd0, bus.contando}, 0);
    step();
    check("t5_contando_rose", {31'd0, bus.contando}, 1);
    n = 0;
    while (!bus.fault && n < 40) begin
      step();
      n++;
    end
    check("t5_fault_delay", n, 20);
    check("t5_fault_out", {20'd0, bus.state_o, bus.ns_light, bus.ew_light, bus.walk, bus.contando, bus.fault},
          {20'd0, 4'd8, 3'b100, 3'b100, 1'b0, 1'b0, 1'b1});
    for (int k = 0; k < 3; k++) begin
      manual_term    = 1'b1;
      bus.ped_req    = 1'b1;
      bus.night_mode = 1'b1;
      step();
      manual_term = 1'b0;
      step();
    end
    check("t5_sticky", {26'd0, bus.state_o, bus.fault, bus.contando}, {26'd0, 4'd8, 1'b1, 1'b0});
    check("t5_sticky_lamps", {25'd0, bus.ns_light, bus.ew_light, bus.walk}, 32'b1001000);
    rst = 1'b1;
    #1;
    check("t5_rst_clears", {27'd0, bus.state_o, bus.fault}, {27'd0, 4'd5, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
Intersection light controller and the initiator side of the timer handshake. It drives time_value and contando to the shared 4-bit interval counter, and advances its state machine on each terminado pulse. It sequences two-road lights, a latched pedestrian walk phase, and a night flash mode. A watchdog locks it into a fault state if terminado never arrives.

Parameters:
T_GREEN, 4'd9, time_value driven in NS_GREEN and EW_GREEN
T_YELLOW, 4'd2, time_value in NS_YELLOW and EW_YELLOW
T_ALLRED, 4'd1, time_value in ALL_RED1 and ALL_RED2
T_WALK, 4'd7, time_value in WALK
T_FLASH, 4'd3, time_value in FLASH (one half-period)
WDOG, 5'd20, watchdog limit in div_clk cycles of contando=1 without terminado

Ports:
div_clk  in  1  clock
rst  in  1  asynchronous, active-high reset
terminado  in  1  one-cycle interval-done pulse from the counter
ped_req  in  1  pedestrian button, level, sampled every edge
night_mode  in  1  request flash operation
time_value  out  4  interval to counter, registered
contando  out  1  counter run enable, registered
ns_light  out  3  {red,yellow,green}, registered
ew_light  out  3  {red,yellow,green}, registered
walk  out  1  pedestrian walk lamp
fault  out  1  sticky watchdog fault
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset: state=ALL_RED2, phase=LOAD, contando=0, time_value=T_ALLRED, ns_light=ew_light=3'b100, walk=0, fault=0, ped_pend=0, wdog_cnt=0, flash_ph=0.
- Each state has two phases.
  - LOAD: contando=0, one cycle; counter holds/clears terminado.
  - RUN: contando=1 until terminado is sampled high.
  - LOAD->RUN happens on the next edge unconditionally.
- On an edge with phase=RUN and terminado=1:
  - Compute the next state.
  - Load its time_value.
  - Update the lights.
  - Set phase=LOAD. contando is 0 after this edge.
- Dwell per state is time_value+3 div_clk cycles, edge of light change to next light change. Example: green = 12 cycles at defaults.
- terminado sampled while phase=LOAD is ignored.
- State encoding: NS_GREEN=0, NS_YELLOW=1, ALL_RED1=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED2=5, WALK=6, FLASH=7, FAULT=8.
- Transitions:
  - NS_GREEN->NS_YELLOW->ALL_RED1->EW_GREEN->EW_YELLOW->ALL_RED2.
  - ALL_RED1: night_mode=1 -> FLASH, else -> EW_GREEN.
  - ALL_RED2: night_mode=1 -> FLASH; else ped_pend=1 -> WALK; else -> NS_GREEN.
  - WALK -> NS_GREEN.
  - FLASH: night_mode=0 at terminado -> ALL_RED2; else stay in FLASH and toggle flash_ph.
- Lights:
  - Green/yellow on the active road.
  - Red on the other road, and on both roads in ALL_RED and WALK.
  - walk=1 only in WALK.
  - FLASH: both roads show yellow=flash_ph, red=0, green=0.
- ped_pend:
  - Set on any edge with ped_req=1.
  - Cleared on the edge entering WALK; the clear wins over a simultaneous set.
  - A request during WALK (after entry) is served next round.
  - ped_req is ignored in FLASH and FAULT (not latched).
- Watchdog:
  - wdog_cnt clears on entering RUN and increments each RUN edge.
  - On an edge with phase=RUN, terminado=0 and wdog_cnt==WDOG-1, go to FAULT.
  - Net effect: fault is entered WDOG cycles after contando rose. Normal max is time_value+2=17 < 20.
- FAULT:
  - contando=0, ns_light=ew_light=3'b100, walk=0, fault=1.
  - Stays until rst. All inputs are ignored.
- night_mode is sampled only at transition points; it has no effect mid-interval.
- rst asserted mid-interval returns immediately to the reset values. The next edge after release enters RUN of ALL_RED2.
- All widths are exact. wdog_cnt is 5 bits and saturates is never needed because FAULT is terminal.

Test Plan:
1. Reset, no inputs, behavioural counter model attached -> contando rises 1 cycle after release. ALL_RED2 lasts 4 cycles, then NS_GREEN 12, NS_YELLOW 5, ALL_RED1 4, EW_GREEN 12, EW_YELLOW 5, back to ALL_RED2. Check ns_light/ew_light values at each state.
2. Pulse ped_req 1 cycle during NS_GREEN -> after ALL_RED2 the FSM goes to WALK (walk=1, both red, 10 cycles), then NS_GREEN. ped_pend is cleared; the next round skips WALK.
3. ped_req high on exactly the edge entering WALK -> no second WALK next round. ped_req during WALK -> WALK repeats next round.
4. night_mode=1 set mid-NS_GREEN -> the FSM completes NS_GREEN/NS_YELLOW normally. At the end of ALL_RED1 it enters FLASH, with yellow toggling every 6 cycles. Drop night_mode -> the next terminado goes to ALL_RED2, then NS_GREEN.
5. Counter stub holding terminado=0 -> fault=1 and both roads red exactly 20 cycles after contando rose. contando=0. fault persists across further terminado pulses until rst.
6. Assert rst for 1 cycle mid EW_GREEN -> all outputs return to reset values asynchronously. The sequence restarts from ALL_RED2 with a 4-cycle dwell.
